// File: rtl/jk_excite_pkg.sv
// Shared types and constants for the dual JK excitation controller.
// Holds FSM state encoding, {J,K} excitation codes and error counter width.
package jk_excite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    FORCE = 2'd2,
    CHECK = 2'd3
  } state_t;

  // {J,K} pairs
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_TOG  = 2'b11;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  function automatic logic [ERR_W-1:0] sat_inc(
    input logic [ERR_W-1:0] v
  );
    return (v == ERR_MAX) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/jk_excite_ctrl_if.sv
// Target request handshake: valid/ready plus desired Q and force flag.
// master = requester, slave = controller.
interface jk_excite_ctrl_if;

  logic       tgt_valid;
  logic       tgt_ready;
  logic [1:2] tgt_data;
  logic       tgt_force;

  modport master (
    output tgt_valid,
    output tgt_data,
    output tgt_force,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_data,
    input  tgt_force,
    output tgt_ready
  );

endinterface

// File: rtl/jk_excite_bit.sv
// Per-bit JK excitation: (q, t, use_toggle) -> (j, k), purely combinational.
// Ports: q current Q, t target, use_toggle mode, j/k excitation.
module jk_excite_bit
  import jk_excite_pkg::*;
(
  input  logic q,
  input  logic t,
  input  logic use_toggle,
  output logic j,
  output logic k
);

  logic [1:0] jk;

  always_comb begin
    jk = JK_HOLD;
    if (use_toggle) begin
      jk = (q != t) ? JK_TOG : JK_HOLD;
    end else begin
      unique case ({q, t})
        2'b01:   jk = JK_SET;
        2'b10:   jk = JK_CLR;
        default: jk = JK_HOLD;
      endcase
    end
  end

  assign j = jk[1];
  assign k = jk[0];

endmodule

// File: rtl/jk_excite_ctrl.sv
// Controller driving a dual negative-edge JK flip-flop to requested values.
// Ports: Clk, RD (async low reset), tgt handshake, J/K/SDo/RDo out, Q_fb in, err.
module jk_excite_ctrl
  import jk_excite_pkg::*;
#(
  parameter int USE_TOGGLE = 0,
  parameter int FORCE_CYC  = 2
) (
  input  logic             Clk,
  input  logic             RD,
  jk_excite_ctrl_if.slave  tgt,
  output logic [1:2]       J,
  output logic [1:2]       K,
  output logic [1:2]       SDo,
  output logic [1:2]       RDo,
  input  logic [1:2]       Q_fb,
  input  logic             err_clr,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic TOG = (USE_TOGGLE != 0);
  // last forced cycle releases; one more cycle lets Q_fb settle
  localparam logic [3:0] FC_REL = 4'(FORCE_CYC - 1);
  localparam logic [3:0] FC_END = 4'(FORCE_CYC);

  state_t     state;
  logic       ready_q;
  logic [1:2] tgt_q;
  logic [3:0] cnt;
  logic [1:2] j_nx;
  logic [1:2] k_nx;
  logic       accept;
  logic       mismatch;

  assign tgt.tgt_ready = ready_q;
  assign accept   = tgt.tgt_valid & ready_q;
  assign mismatch = (Q_fb != tgt_q);

  jk_excite_bit u_bit1 (
    .q          (Q_fb[1]),
    .t          (tgt.tgt_data[1]),
    .use_toggle (TOG),
    .j          (j_nx[1]),
    .k          (k_nx[1])
  );

  jk_excite_bit u_bit2 (
    .q          (Q_fb[2]),
    .t          (tgt.tgt_data[2]),
    .use_toggle (TOG),
    .j          (j_nx[2]),
    .k          (k_nx[2])
  );

  always_ff @(posedge Clk or negedge RD) begin
    if (!RD) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      tgt_q   <= '0;
      cnt     <= '0;
      J       <= '0;
      K       <= '0;
      SDo     <= '1;
      RDo     <= '1;
      done    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      J    <= '0;
      K    <= '0;
      done <= 1'b0;
      if (err_clr) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            tgt_q   <= tgt.tgt_data;
            cnt     <= '0;
            if (tgt.tgt_force) begin
              state <= FORCE;
              SDo   <= ~tgt.tgt_data;
              RDo   <= tgt.tgt_data;
            end else begin
              state <= DRIVE;
              J     <= j_nx;
              K     <= k_nx;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        DRIVE: begin
          state <= CHECK;
          done  <= 1'b1;
        end
        FORCE: begin
          if (cnt == FC_REL) begin
            SDo <= '1;
            RDo <= '1;
          end
          if (cnt == FC_END) begin
            state <= CHECK;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        CHECK: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          if (mismatch) begin
            err     <= 1'b1;
            err_cnt <= err_clr ? ERR_W'(1) : sat_inc(err_cnt);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// Bench for jk_excite_ctrl: set/reset and toggle instances side by side,
// each closed through a behavioural dual JK flip-flop model.
module tb_jk_excite_ctrl;

  localparam int FC = 2;

  logic clk;
  logic rd;
  logic err_clr;
  logic stuck;

  logic [1:2] j0, k0, sdo0, rdo0, qfb0, ff0;
  logic [1:2] j1, k1, sdo1, rdo1, qfb1, ff1;
  logic       done0, err0, done1, err1;
  logic [7:0] cnt0, cnt1;

  int total;
  int bad;

  logic [1:2] mq;
  logic       m_sync;
  logic       m_err;
  int         m_cnt;

  jk_excite_ctrl_if bus0 ();
  jk_excite_ctrl_if bus1 ();

  jk_excite_ctrl #(.USE_TOGGLE(0), .FORCE_CYC(FC)) dut0 (
    .Clk(clk), .RD(rd), .tgt(bus0.slave),
    .J(j0), .K(k0), .SDo(sdo0), .RDo(rdo0), .Q_fb(qfb0),
    .err_clr(err_clr), .done(done0), .err(err0), .err_cnt(cnt0)
  );

  jk_excite_ctrl #(.USE_TOGGLE(1), .FORCE_CYC(FC)) dut1 (
    .Clk(clk), .RD(rd), .tgt(bus1.slave),
    .J(j1), .K(k1), .SDo(sdo1), .RDo(rdo1), .Q_fb(qfb1),
    .err_clr(err_clr), .done(done1), .err(err1), .err_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:2] ff_next(
    input logic [1:2] q, j, k, s, r
  );
    logic [1:2] n;
    for (int b = 1; b <= 2; b++) begin
      if (!s[b]) n[b] = 1'b1;
      else if (!r[b]) n[b] = 1'b0;
      else begin
        case ({j[b], k[b]})
          2'b10:   n[b] = 1'b1;
          2'b01:   n[b] = 1'b0;
          2'b11:   n[b] = ~q[b];
          default: n[b] = q[b];
        endcase
      end
    end
    return n;
  endfunction

  initial begin
    ff0 = '0;
    ff1 = '0;
  end

  always @(negedge clk) begin
    ff0 <= ff_next(ff0, j0, k0, sdo0, rdo0);
    ff1 <= ff_next(ff1, j1, k1, sdo1, rdo1);
  end

  assign qfb0 = stuck ? 2'b00 : ((ff0 | ~sdo0) & rdo0);
  assign qfb1 = stuck ? 2'b00 : ((ff1 | ~sdo1) & rdo1);

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic v, input logic [1:2] d,
                         input logic f);
    bus0.tgt_valid = v; bus0.tgt_data = d; bus0.tgt_force = f;
    bus1.tgt_valid = v; bus1.tgt_data = d; bus1.tgt_force = f;
  endtask

  task automatic noise();
    set_bus(1'($urandom), 2'($urandom), 1'($urandom));
  endtask

  task automatic do_req(input logic [1:2] t, input logic f,
                        input logic clr,
                        input logic [1:2] ej0, ek0, ej1, ek1, es, er);
    int n;
    logic mis;
    n = 0;
    while (!bus0.tgt_ready && n < 10) begin
      step();
      n++;
    end
    chk("ready_in", 32'({bus1.tgt_ready, bus0.tgt_ready}), 32'd3);
    set_bus(1'b1, t, f);
    step();
    if (!f) begin
      chk("j0", 32'(j0), 32'(ej0));
      chk("k0", 32'(k0), 32'(ek0));
      chk("j1", 32'(j1), 32'(ej1));
      chk("k1", 32'(k1), 32'(ek1));
      chk("sr_drv", 32'({sdo0, rdo0, sdo1, rdo1}), 32'hFF);
      chk("done_drv", 32'({done1, done0}), 32'd0);
      noise();
      step();
    end else begin
      for (int i = 0; i < FC; i++) begin
        chk("sdo0", 32'(sdo0), 32'(es));
        chk("rdo0", 32'(rdo0), 32'(er));
        chk("sr1", 32'({sdo1, rdo1}), 32'({es, er}));
        chk("jk_frc", 32'({j0, k0, j1, k1}), 32'd0);
        chk("done_frc", 32'({done1, done0}), 32'd0);
        noise();
        step();
      end
      chk("sr_rel", 32'({sdo0, rdo0, sdo1, rdo1}), 32'hFF);
      chk("done_rel", 32'({done1, done0}), 32'd0);
      noise();
      step();
    end
    chk("done", 32'({done1, done0}), 32'd3);
    chk("jk_chk", 32'({j0, k0, j1, k1}), 32'd0);
    err_clr = clr;
    noise();
    step();
    err_clr = 1'b0;
    set_bus(1'b0, 2'b00, 1'b0);
    chk("done_end", 32'({done1, done0}), 32'd0);
    chk("ready_out", 32'({bus1.tgt_ready, bus0.tgt_ready}), 32'd3);
    mis = stuck && (t != 2'b00);
    if (clr) begin
      m_err = mis;
      m_cnt = mis ? 1 : 0;
    end else if (mis) begin
      m_err = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    chk("err0", 32'(err0), 32'(m_err));
    chk("err1", 32'(err1), 32'(m_err));
    chk("cnt0", 32'(cnt0), 32'(m_cnt));
    chk("cnt1", 32'(cnt1), 32'(m_cnt));
    if (f) begin
      mq = t;
      m_sync = 1'b1;
    end else if (stuck) begin
      m_sync = 1'b0;
    end else begin
      mq = t;
    end
  endtask

  task automatic model_req(input logic [1:2] t, input logic f,
                           input logic clr);
    logic [1:2] obs;
    obs = stuck ? 2'b00 : mq;
    do_req(t, f, clr, t & ~obs, ~t & obs, t ^ obs, t ^ obs, ~t, t);
  endtask

  typedef struct {
    logic [1:2] t;
    logic       f;
    logic [1:2] ej0, ek0, ej1, ek1, es, er;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{2'b10, 1'b0, 2'b10, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11};
    tbl[1] = '{2'b11, 1'b0, 2'b01, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11};
    tbl[2] = '{2'b01, 1'b0, 2'b00, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    tbl[3] = '{2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11};
    tbl[4] = '{2'b10, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
    tbl[5] = '{2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01};
    tbl[6] = '{2'b00, 1'b0, 2'b00, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11};
    tbl[7] = '{2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    tbl[8] = '{2'b00, 1'b0, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};

    total = 0;
    bad = 0;
    mq = 2'b00;
    m_sync = 1'b1;
    m_err = 1'b0;
    m_cnt = 0;
    stuck = 1'b0;
    err_clr = 1'b0;
    set_bus(1'b0, 2'b00, 1'b0);
    rd = 1'b1;
    #3 rd = 1'b0;

    // reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_ready", 32'({bus1.tgt_ready, bus0.tgt_ready}), 32'd0);
    chk("rst_sr", 32'({sdo0, rdo0, sdo1, rdo1}), 32'hFF);
    chk("rst_jk", 32'({j0, k0, j1, k1}), 32'd0);
    chk("rst_done", 32'({done1, done0}), 32'd0);
    chk("rst_err", 32'({err1, err0, cnt1, cnt0}), 32'd0);
    rd = 1'b1;
    #1;
    chk("rel_ready0", 32'(bus0.tgt_ready), 32'd0);
    step();
    chk("rel_ready1", 32'({bus1.tgt_ready, bus0.tgt_ready}), 32'd3);

    for (int i = 0; i < 9; i++)
      do_req(tbl[i].t, tbl[i].f, 1'b0, tbl[i].ej0, tbl[i].ek0,
             tbl[i].ej1, tbl[i].ek1, tbl[i].es, tbl[i].er);

    // reset in the middle of a forced load
    set_bus(1'b1, 2'b01, 1'b1);
    step();
    set_bus(1'b0, 2'b00, 1'b0);
    chk("mf_sdo", 32'({sdo0, rdo0}), 32'({2'b10, 2'b01}));
    #2 rd = 1'b0;
    #1;
    chk("mf_rel", 32'({sdo0, rdo0, sdo1, rdo1}), 32'hFF);
    chk("mf_ready", 32'({bus1.tgt_ready, bus0.tgt_ready}), 32'd0);
    m_err = 1'b0;
    m_cnt = 0;
    step();
    rd = 1'b1;
    #1;
    chk("mf_ready_lo", 32'(bus0.tgt_ready), 32'd0);
    step();
    chk("mf_ready_hi", 32'({bus1.tgt_ready, bus0.tgt_ready}), 32'd3);
    model_req(2'b10, 1'b0, 1'b0);

    // stuck feedback saturates the counter
    stuck = 1'b1;
    for (int i = 0; i < 260; i++)
      model_req(2'b11, 1'b0, 1'b0);
    chk("sat_cnt", 32'(cnt0), 32'd255);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
    chk("clr_only", 32'({err1, err0, cnt1, cnt0}), 32'd0);
    model_req(2'b10, 1'b0, 1'b1);
    stuck = 1'b0;
    model_req(2'b01, 1'b1, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      logic [1:2] t;
      logic f;
      logic c;
      stuck = ($urandom_range(7) == 0);
      t = 2'($urandom);
      f = 1'($urandom);
      if (!m_sync && !stuck) f = 1'b1;
      c = ($urandom_range(9) == 0);
      model_req(t, f, c);
    end
    stuck = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
